bus_requester: RTL and testbench

//  Initiator-side agent for the request/grant ownership protocol driven by the

---
 rtl/bus_requester.sv | 133 +++++++++++++
 tb/tb_bus_requester.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_requester.sv
// Initiator-side request/grant agent: asks the arbiter for ownership, paces a
// burst of len+1 beats while granted, then releases. Optional macro REQ_TIMEOUT_EN.
module bus_requester #(
  parameter int LEN_W    = 4,
  parameter int MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             valid,
  output logic             ready,
  output logic             request,
  input  logic             grant,
  output logic             active,
  output logic [LEN_W-1:0] beat,
  output logic             ack,
  output logic             abort,
  output logic [1:0]       state_dbg
);

  // Handshakes: start is taken only in a cycle where ready=1; a beat is
  // consumed only in a cycle where active=1 and valid=1 (active = OWN & grant).

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_OWN     = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic             ack_q, ack_d;

`ifdef REQ_TIMEOUT_EN
  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              abort_q, abort_d;
`endif

  // Request is derived from state so an asynchronous reset drops it at once.
  assign ready     = (state_q == S_IDLE);
  assign request   = (state_q == S_REQ) || (state_q == S_OWN);
  assign active    = (state_q == S_OWN) && grant;
  assign beat      = beat_q;
  assign ack       = ack_q;
  assign state_dbg = state_q;

`ifdef REQ_TIMEOUT_EN
  assign abort = abort_q;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    ack_d   = 1'b0;
`ifdef REQ_TIMEOUT_EN
    wait_d  = wait_q;
    abort_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          beat_d  = '0;
          state_d = S_REQ;
`ifdef REQ_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      S_REQ: begin
        if (grant) begin
          state_d = S_OWN;
`ifdef REQ_TIMEOUT_EN
        end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
          state_d = S_RELEASE;
          abort_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
`endif
        end
      end
      S_OWN: begin
        // Losing grant mid-burst simply freezes the beat index.
        if (grant && valid) begin
          if (beat_q == len_q) begin
            state_d = S_RELEASE;
            ack_d   = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_RELEASE: begin
        if (!grant) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      ack_q   <= ack_d;
    end
  end

`ifdef REQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      abort_q <= abort_d;
    end
  end
`endif

endmodule

// File: tb/tb_bus_requester.sv
// Directed bench for bus_requester: per-cycle vector table plus hand sequences
// for max-length burst, asynchronous reset mid-burst and grant-wait timeout.
module tb_bus_requester;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic       valid;
  logic       ready;
  logic       request;
  logic       grant;
  logic       active;
  logic [3:0] beat;
  logic       ack;
  logic       abort;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  bus_requester #(.LEN_W(4), .MAX_WAIT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .valid(valid),
    .ready(ready), .request(request), .grant(grant), .active(active),
    .beat(beat), .ack(ack), .abort(abort), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [3:0] len;
    logic       valid;
    logic       grant;
    logic       ready;
    logic       request;
    logic       active;
    logic [3:0] beat;
    logic       ack;
    logic       abort;
  } vec_t;

  vec_t vecs[$];

  // Args: start len valid grant | ready request active beat ack abort
  function automatic vec_t mk(logic s, logic [3:0] l, logic v, logic g,
                              logic rd, logic rq, logic ac, logic [3:0] b,
                              logic ak, logic ab);
    vec_t r;
    r.start = s;  r.len = l;  r.valid = v;  r.grant = g;
    r.ready = rd; r.request = rq; r.active = ac; r.beat = b;
    r.ack = ak;   r.abort = ab;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  // Inputs are applied just after a rising edge and outputs checked mid-cycle.
  task automatic drive(input logic s, input logic [3:0] l, input logic v, input logic g);
    start = s; len = l; valid = v; grant = g;
    #2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] pack_out(logic rd, logic rq, logic ac, logic [3:0] b,
                                          logic ak, logic ab);
    return {rd, rq, ac, b, ak, ab};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; valid = 1'b0; grant = 1'b0;

    // basic len=3, grant held, valid=1
    vecs.push_back(mk(1, 3, 0, 1,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1,  0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1,  0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1,  0, 1, 1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1,  0, 1, 1, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 3, 0, 0));
    // stall len=2, valid 1,0,1,0,1
    vecs.push_back(mk(1, 2, 0, 1,  1, 0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1,  0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1,  0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1,  0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1,  0, 1, 1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1,  0, 1, 1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 2, 0, 0));
    // preempt len=5: late grant, drop after beat 2 for 4 cycles
    vecs.push_back(mk(1, 5, 1, 0,  1, 0, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1,  0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1,  0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0,  0, 1, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0,  0, 1, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0,  0, 1, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0,  0, 1, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1,  0, 1, 1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1,  0, 1, 1, 3, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1,  0, 1, 1, 4, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1,  0, 1, 1, 5, 0, 0));
    // release: grant held 3 cycles, start ignored
    vecs.push_back(mk(1, 0, 0, 1,  0, 0, 0, 5, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1,  0, 0, 0, 5, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1,  0, 0, 0, 5, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 5, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 5, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 5, 0, 0));
    // minimum burst len=0 -> one beat
    vecs.push_back(mk(1, 0, 1, 1,  1, 0, 0, 5, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1,  0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1,  0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {22'd0, pack_out(ready, request, active, beat, ack, abort)},
        {22'd0, pack_out(1, 0, 0, 0, 0, 0)});
    rst = 1'b0;
    next_cycle();

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].len, vecs[i].valid, vecs[i].grant);
      chk($sformatf("vec%0d", i),
          {22'd0, pack_out(ready, request, active, beat, ack, abort)},
          {22'd0, pack_out(vecs[i].ready, vecs[i].request, vecs[i].active,
                           vecs[i].beat, vecs[i].ack, vecs[i].abort)});
      next_cycle();
    end

    // maximum burst len=15 -> 16 beats, no wrap
    drive(1, 4'd15, 1, 1);
    chk("max_ready", {31'd0, ready}, 32'd1);
    next_cycle();
    drive(0, 0, 1, 1);
    chk("max_req", {31'd0, request}, 32'd1);
    next_cycle();
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 1);
      chk($sformatf("max_beat%0d", i), {27'd0, active, beat}, {27'd0, 1'b1, 4'(i)});
      next_cycle();
    end
    drive(0, 0, 0, 0);
    chk("max_done", {28'd0, request, active, ack, abort}, {28'd0, 4'b0010});
    chk("max_beat_hold", {28'd0, beat}, 32'd15);
    next_cycle();

    // asynchronous reset mid-OWN
    drive(1, 4'd7, 1, 1);
    next_cycle();
    drive(0, 0, 1, 1);
    next_cycle();
    drive(0, 0, 1, 1);
    next_cycle();
    drive(0, 0, 1, 1);
    chk("pre_rst_own", {27'd0, active, beat}, {27'd0, 1'b1, 4'd1});
    rst = 1'b1;
    #1;
    chk("async_rst", {22'd0, pack_out(ready, request, active, beat, ack, abort)},
        {22'd0, pack_out(1, 0, 0, 0, 0, 0)});
    next_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0);
    chk("post_rst_idle", {30'd0, ready, request}, {30'd0, 2'b10});
    next_cycle();

    // grant never asserted
    drive(1, 4'd2, 0, 0);
    next_cycle();
    for (int i = 1; i <= 16; i++) begin
      drive(0, 0, 0, 0);
      chk($sformatf("wait%0d", i), {29'd0, request, ack, abort}, {29'd0, 3'b100});
      next_cycle();
    end
`ifdef REQ_TIMEOUT_EN
    drive(0, 0, 0, 0);
    chk("timeout_abort", {28'd0, request, ready, ack, abort}, {28'd0, 4'b0001});
    next_cycle();
    drive(0, 0, 0, 0);
    chk("timeout_idle", {28'd0, request, ready, ack, abort}, {28'd0, 4'b0100});
    next_cycle();
`else
    for (int i = 17; i <= 40; i++) begin
      drive(0, 0, 0, 0);
      chk($sformatf("wait%0d", i), {29'd0, request, ack, abort}, {29'd0, 3'b100});
      next_cycle();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
